// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: access sizes and FSM states.
// mem_size_t value 3 is deliberately left unnamed; it is the illegal size.
package common;

    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD
    } mem_size_t;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_RESP
    } dmem_state_t;

    localparam int DM_CNT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between mem_stage and the responder.
interface dmem_responder_if
    import common::*;
#(
    parameter int ADDR_WIDTH = 10
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    mem_size_t             req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned,
        output req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned,
        input  req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );

endinterface

// File: rtl/dmem_responder_mem_lane_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
module mem_lane_align
    import common::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_raw,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

    always_comb begin
        o_misalign = 1'b0;
        o_byte_en  = 4'b0000;
        o_wdata    = 32'h0;
        o_rdata    = 32'h0;
        case (i_size)
            MEM_BYTE: begin
                o_byte_en = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
                o_rdata   = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            MEM_HALF: begin
                o_misalign = i_addr_lo[0];
                o_byte_en  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            MEM_WORD: begin
                o_misalign = |i_addr_lo;
                o_byte_en  = 4'b1111;
                o_wdata    = i_wdata;
                o_rdata    = i_raw;
            end
            default: o_misalign = 1'b1;
        endcase
        // A faulting access must neither write lanes nor return data.
        if (o_misalign) begin
            o_byte_en = 4'b0000;
            o_rdata   = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response after LATENCY cycles.
module dmem_responder
    import common::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
)(
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam logic [DM_CNT_W-1:0] CNT_INIT = DM_CNT_W'(LATENCY - 1);

    logic [31:0] r_ram [WORDS];

    dmem_state_t         r_state;
    dmem_state_t         w_state_nx;
    logic [DM_CNT_W-1:0] r_cnt;
    logic [DM_CNT_W-1:0] w_cnt_nx;
    logic [31:0]         r_rdata;
    logic [31:0]         w_rdata_nx;
    logic                r_error;
    logic                w_error_nx;
    logic                w_we;

    logic [ADDR_WIDTH-3:0] w_idx;
    logic [3:0]            w_ben;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ld_data;
    logic                  w_misalign;

    assign w_idx = bus.req_addr[ADDR_WIDTH-1:2];

    mem_lane_align u_align (
        .i_size     (bus.req_size),
        .i_addr_lo  (bus.req_addr[1:0]),
        .i_unsigned (bus.req_unsigned),
        .i_wdata    (bus.req_wdata),
        .i_raw      (r_ram[w_idx]),
        .o_byte_en  (w_ben),
        .o_wdata    (w_wdata),
        .o_rdata    (w_ld_data),
        .o_misalign (w_misalign)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rdata_nx = r_rdata;
        w_error_nx = r_error;
        w_we       = 1'b0;
        unique case (r_state)
            DM_IDLE: begin
                if (bus.req_valid) begin
                    w_we       = bus.req_write & ~w_misalign;
                    w_rdata_nx = bus.req_write ? 32'h0 : w_ld_data;
                    w_error_nx = w_misalign;
                    w_cnt_nx   = CNT_INIT;
                    w_state_nx = (LATENCY == 1) ? DM_RESP : DM_WAIT;
                end
            end
            DM_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nx = DM_RESP;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            DM_RESP: begin
                if (bus.resp_ready) begin
                    w_state_nx = DM_IDLE;
                    w_rdata_nx = 32'h0;
                    w_error_nx = 1'b0;
                end
            end
            default: w_state_nx = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DM_IDLE;
            r_cnt   <= '0;
            r_rdata <= 32'h0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rdata <= w_rdata_nx;
            r_error <= w_error_nx;
        end
    end

    // RAM contents survive reset; only the request in flight is dropped.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we && !reset && w_ben[b]) begin
                r_ram[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    assign bus.req_ready  = (r_state == DM_IDLE);
    assign bus.resp_valid = (r_state == DM_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_error = r_error;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-array reference model.
module tb_dmem_responder;
    import common::*;

    localparam int AW = 10;
    localparam int L  = 3;

    logic clk;
    logic reset;

    dmem_responder_if #(.ADDR_WIDTH(AW)) bus ();

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    bit armed = 1'b0;

    logic [7:0]  mem [2**AW];
    bit          m_busy = 1'b0;
    int          m_acc  = 0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    function automatic void model_access(input logic w, input logic [1:0] sz,
                                         input logic u, input logic [AW-1:0] a,
                                         input logic [31:0] wd);
        int n;
        logic [31:0] v;
        m_err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                  (sz == 2'd2 && a[1:0] != 2'b00);
        m_rdata = 32'h0;
        if (m_err) return;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (w) begin
            for (int i = 0; i < n; i++) mem[a + AW'(i)] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mem[a + AW'(i)];
            if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            m_rdata = v;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_busy = 1'b0;
            armed  = 1'b1;
        end else if (m_busy) begin
            if (cyc - m_acc > L && bus.resp_ready) m_busy = 1'b0;
        end else if (bus.req_valid) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            model_access(bus.req_write, bus.req_size, bus.req_unsigned,
                         bus.req_addr, bus.req_wdata);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic ev;
            ev = m_busy && (cyc - m_acc >= L);
            check("req_ready", 32'(bus.req_ready), 32'(!m_busy));
            check("resp_valid", 32'(bus.resp_valid), 32'(ev));
            if (ev) begin
                check("resp_rdata", bus.resp_rdata, m_rdata);
                check("resp_error", 32'(bus.resp_error), 32'(m_err));
            end else if (!m_busy) begin
                check("idle_rdata", bus.resp_rdata, 32'h0);
                check("idle_error", 32'(bus.resp_error), 32'h0);
            end
        end
    end

    task automatic txn(input logic w, input logic [1:0] sz, input logic u,
                       input logic [AW-1:0] a, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd,
                       output logic er, output int lat);
        int t;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = mem_size_t'(sz);
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.resp_ready   = (hold == 0);
        t = 0;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_in_time", 32'(t < 50), 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("resp_in_time", 32'(lat < 50), 32'h1);
        rd = bus.resp_rdata;
        er = bus.resp_error;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("hold_rdy_lo", 32'(bus.req_ready), 32'h0);
            check("hold_data", bus.resp_rdata, rd);
            bus.resp_ready = 1'b1;
            @(negedge clk);
            check("rdy_after_hs", 32'(bus.req_ready), 32'h1);
        end else begin
            @(negedge clk);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = MEM_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = 32'h0;
        bus.resp_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        reset = 1'b0;

        txn(1, 2'd2, 0, 10'h010, 32'hDEAD_BEEF, 0, rd, er, lat);
        check("st_w_rdata", rd, 32'h0);
        check("st_w_lat", 32'(lat), 32'(L));
        txn(0, 2'd2, 0, 10'h010, 32'h0, 0, rd, er, lat);
        check("ld_w_010", rd, 32'hDEAD_BEEF);
        check("ld_w_010_err", 32'(er), 32'h0);

        txn(1, 2'd0, 0, 10'h013, 32'h0000_007F, 0, rd, er, lat);
        txn(0, 2'd0, 0, 10'h013, 32'h0, 0, rd, er, lat);
        check("ld_bs_013", rd, 32'h0000_007F);
        txn(0, 2'd2, 0, 10'h010, 32'h0, 0, rd, er, lat);
        check("ld_w_010b", rd, 32'h7FAD_BEEF);

        txn(1, 2'd0, 0, 10'h011, 32'h1234_5680, 0, rd, er, lat);
        txn(0, 2'd0, 0, 10'h011, 32'h0, 0, rd, er, lat);
        check("ld_bs_011", rd, 32'hFFFF_FF80);
        txn(0, 2'd0, 1, 10'h011, 32'h0, 0, rd, er, lat);
        check("ld_bu_011", rd, 32'h0000_0080);

        txn(1, 2'd2, 0, 10'h020, 32'h1122_3344, 0, rd, er, lat);
        txn(1, 2'd1, 0, 10'h022, 32'hABCD_8001, 0, rd, er, lat);
        txn(0, 2'd1, 0, 10'h022, 32'h0, 0, rd, er, lat);
        check("ld_hs_022", rd, 32'hFFFF_8001);
        txn(0, 2'd1, 1, 10'h022, 32'h0, 0, rd, er, lat);
        check("ld_hu_022", rd, 32'h0000_8001);
        txn(0, 2'd2, 0, 10'h020, 32'h0, 0, rd, er, lat);
        check("ld_w_020", rd, 32'h8001_3344);

        txn(0, 2'd1, 0, 10'h021, 32'h0, 0, rd, er, lat);
        check("mis_h_err", 32'(er), 32'h1);
        check("mis_h_rdata", rd, 32'h0);
        txn(1, 2'd2, 0, 10'h012, 32'h5555_5555, 0, rd, er, lat);
        check("mis_w_err", 32'(er), 32'h1);
        txn(0, 2'd3, 0, 10'h010, 32'h0, 0, rd, er, lat);
        check("size3_err", 32'(er), 32'h1);
        txn(0, 2'd2, 0, 10'h010, 32'h0, 0, rd, er, lat);
        check("no_change_010", rd, 32'h7FAD_80EF);

        txn(1, 2'd0, 0, 10'h3FF, 32'h0000_00A5, 0, rd, er, lat);
        txn(0, 2'd0, 1, 10'h3FF, 32'h0, 0, rd, er, lat);
        check("ld_bu_3ff", rd, 32'h0000_00A5);

        txn(0, 2'd2, 0, 10'h020, 32'h0, 4, rd, er, lat);
        check("hold_lat", 32'(lat), 32'(L));
        check("hold_rdata", rd, 32'h8001_3344);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = MEM_WORD;
        bus.req_addr  = 10'h030;
        bus.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_wait_ready", 32'(bus.req_ready), 32'h1);
        check("rst_wait_valid", 32'(bus.resp_valid), 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("dropped_resp", 32'(bus.resp_valid), 32'h0);
        end
        txn(0, 2'd2, 0, 10'h030, 32'h0, 0, rd, er, lat);
        check("committed_030", rd, 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
